// File: rtl/sysid_check_arbiter.sv
// Power-up integrity check of the system-ID slave (ID + timestamp, with retries), then host read arbitration onto it.
// Optional periodic re-check is enabled with `define SYSID_PERIODIC_CHECK_EN.
module sysid_check_arbiter #(
  parameter logic [31:0] EXP_ID    = 32'h0000_0000,
  parameter logic [31:0] EXP_TS    = 32'h0000_0000,
  parameter int          RD_LAT    = 1,
  parameter int          MAX_RETRY = 3,
  parameter int          PERIOD    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_read,
  input  logic        host_address,
  output logic        host_waitrequest,
  output logic [31:0] host_readdata,
  output logic        host_readdatavalid,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        check_done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        check_fail,
  output logic [2:0]  retry_cnt
);

  localparam int DATA_W = 32;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("sysid_check_arbiter: RD_LAT=%0d outside 1..4", RD_LAT);
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_max_retry
    $error("sysid_check_arbiter: MAX_RETRY=%0d outside 0..7", MAX_RETRY);
  end

  localparam logic [2:0] LAT_LAST  = 3'(RD_LAT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_CHK_ID,
    S_CHK_TS,
    S_CMP,
    S_PASS,
    S_FAIL,
    S_HOST_RD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_wcnt;
  logic              r_sid_addr;
  logic              r_waitreq;
  logic              r_done;
  logic              r_id_ok;
  logic              r_ts_ok;
  logic              r_fail;
  logic [2:0]        r_retry;
  logic              r_ret_fail;
  logic [DATA_W-1:0] r_id_p1;
  logic [DATA_W-1:0] r_ts_p1;
  logic [DATA_W-1:0] r_rdata_p1;
  logic              r_rvld_p1;

  logic w_wlast;
  logic w_waiting;
  logic w_id_match;
  logic w_ts_match;
  logic w_accept;
  logic w_restart;
  logic w_expire;
  logic w_recheck;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign w_wlast    = (r_wcnt == LAT_LAST);
  assign w_waiting  = (r_state == S_CHK_ID) || (r_state == S_CHK_TS) || (r_state == S_HOST_RD);
  assign w_id_match = (r_id_p1 == EXP_ID);
  assign w_ts_match = (r_ts_p1 == EXP_TS);
  assign w_restart  = (w_next == S_CHK_ID) &&
                      ((r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_HOST_RD));

`ifdef SYSID_PERIODIC_CHECK_EN
  localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

  if (PERIOD < 16) begin : g_bad_period
    $error("sysid_check_arbiter: PERIOD=%0d below 16", PERIOD);
  end

  logic [PER_W-1:0] r_per_cnt;
  logic             r_recheck;

  assign w_expire  = (r_per_cnt == PER_LAST);
  assign w_recheck = r_recheck;

  // Re-check timer: restarts on every entry to a resolved state; an expiry
  // that coincides with an accepted host read is deferred to HOST_RD exit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_per_cnt <= '0;
      r_recheck <= 1'b0;
    end else begin
      if ((r_state == S_PASS) || (r_state == S_FAIL)) begin
        r_per_cnt <= r_per_cnt + PER_W'(1);
        if (w_accept) r_recheck <= w_expire;
      end else begin
        r_per_cnt <= '0;
      end
      if (r_state == S_HOST_RD && w_wlast) r_recheck <= 1'b0;
    end
  end
`else
  assign w_expire  = 1'b0;
  assign w_recheck = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_CHK_ID:  if (w_wlast) w_next = S_CHK_TS;
      S_CHK_TS:  if (w_wlast) w_next = S_CMP;
      S_CMP: begin
        if (w_id_match && w_ts_match) w_next = S_PASS;
        else if (r_retry < RETRY_MAX) w_next = S_CHK_ID;
        else                          w_next = S_FAIL;
      end
      S_PASS, S_FAIL: begin
        if (host_read) begin
          w_accept = 1'b1;
          w_next   = S_HOST_RD;
        end else if (w_expire) begin
          w_next = S_CHK_ID;
        end
      end
      S_HOST_RD: begin
        if (w_wlast) begin
          if (w_recheck)       w_next = S_CHK_ID;
          else if (r_ret_fail) w_next = S_FAIL;
          else                 w_next = S_PASS;
        end
      end
      default:   w_next = S_CHK_ID;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_CHK_ID;
      r_wcnt     <= '0;
      r_sid_addr <= 1'b0;
      r_waitreq  <= 1'b1;
      r_done     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_fail     <= 1'b0;
      r_retry    <= '0;
      r_ret_fail <= 1'b0;
      r_rvld_p1  <= 1'b0;
      r_rdata_p1 <= '0;
    end else begin
      r_state   <= w_next;
      r_waitreq <= !((w_next == S_PASS) || (w_next == S_FAIL));
      r_rvld_p1 <= 1'b0;

      if (w_next != r_state) r_wcnt <= '0;
      else if (w_waiting)    r_wcnt <= r_wcnt + 3'd1;

      if (w_next == S_CHK_ID)      r_sid_addr <= 1'b0;
      else if (w_next == S_CHK_TS) r_sid_addr <= 1'b1;
      else if (w_accept)           r_sid_addr <= host_address;

      if (w_restart) begin
        r_done  <= 1'b0;
        r_retry <= '0;
      end

      if (r_state == S_CMP) begin
        r_id_ok <= w_id_match;
        r_ts_ok <= w_ts_match;
        if (w_next == S_CHK_ID) begin
          r_retry <= sat_inc3(r_retry);
        end else begin
          r_done     <= 1'b1;
          r_ret_fail <= (w_next == S_FAIL);
          if (w_next == S_FAIL) r_fail <= 1'b1;
        end
      end

      // Host read stage: slave word registered onto the host bus with its strobe.
      if (r_state == S_HOST_RD && w_wlast) begin
        r_rvld_p1  <= 1'b1;
        r_rdata_p1 <= sid_readdata;
      end
    end
  end

  // Check capture stage: data registers carry no reset, they are always written before CMP.
  always_ff @(posedge clock) begin
    if (r_state == S_CHK_ID && w_wlast) r_id_p1 <= sid_readdata;
    if (r_state == S_CHK_TS && w_wlast) r_ts_p1 <= sid_readdata;
  end

  assign host_waitrequest   = r_waitreq;
  assign host_readdata      = r_rdata_p1;
  assign host_readdatavalid = r_rvld_p1;
  assign sid_address        = r_sid_addr;
  assign check_done         = r_done;
  assign id_ok              = r_id_ok;
  assign ts_ok              = r_ts_ok;
  assign check_fail         = r_fail;
  assign retry_cnt          = r_retry;

endmodule

// File: tb/tb_sysid_check_arbiter.sv
// Directed bench for sysid_check_arbiter: EXP_ID=1234_5678, EXP_TS=AA, RD_LAT=2, MAX_RETRY=3, PERIOD=16.
// Cycle 1 is the first cycle after the last clock edge that samples reset high.
module tb_sysid_check_arbiter;

  localparam logic [31:0] ID_GOOD = 32'h1234_5678;
  localparam logic [31:0] TS_GOOD = 32'h0000_00AA;
  localparam logic [31:0] ID_BAD  = 32'h8765_4321;
  localparam logic [31:0] TS_BAD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_read = 1'b0;
  logic        host_address = 1'b0;
  logic        host_waitrequest;
  logic [31:0] host_readdata;
  logic        host_readdatavalid;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        check_done, id_ok, ts_ok, check_fail;
  logic [2:0]  retry_cnt;

  logic [31:0] slave_id = ID_GOOD;
  logic [31:0] slave_ts = TS_GOOD;

  int n_vec = 0;
  int n_err = 0;

  assign sid_readdata = sid_address ? slave_ts : slave_id;

  sysid_check_arbiter #(
    .EXP_ID(ID_GOOD), .EXP_TS(TS_GOOD), .RD_LAT(2), .MAX_RETRY(3), .PERIOD(16)
  ) dut (
    .clock(clk), .reset(reset),
    .host_read(host_read), .host_address(host_address),
    .host_waitrequest(host_waitrequest), .host_readdata(host_readdata),
    .host_readdatavalid(host_readdatavalid),
    .sid_address(sid_address), .sid_readdata(sid_readdata),
    .check_done(check_done), .id_ok(id_ok), .ts_ok(ts_ok),
    .check_fail(check_fail), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Issues one host read; reports stall cycles, accept-to-valid latency, data and strobe count.
  task automatic do_read(input logic addr, output int waited, output int lat,
                         output logic [31:0] data, output int nstrobe);
    host_read = 1'b1;
    host_address = addr;
    waited = 0;
    while (host_waitrequest && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    host_read = 1'b0;
    lat = 1;
    while (!host_readdatavalid && lat < 20) begin
      tick();
      lat++;
    end
    data = host_readdata;
    nstrobe = host_readdatavalid ? 1 : 0;
    repeat (5) begin
      tick();
      if (host_readdatavalid) nstrobe++;
    end
  endtask

  task automatic test_reset();
    host_read = 1'b1;
    host_address = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    n_vec++; if (host_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_waitreq: got %b want 1", host_waitrequest); end
    n_vec++; if (host_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_rdvalid: got %b want 0", host_readdatavalid); end
    n_vec++; if (host_readdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", host_readdata); end
    n_vec++; if (sid_address !== 1'b0) begin n_err++; $display("FAIL rst_sid_addr: got %b want 0", sid_address); end
    n_vec++; if ({check_done, id_ok, ts_ok, check_fail} !== 4'b0000) begin n_err++; $display("FAIL rst_status: got %b want 0000", {check_done, id_ok, ts_ok, check_fail}); end
    n_vec++; if (retry_cnt !== 3'd0) begin n_err++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
    host_read = 1'b0;
  endtask

  task automatic test_pass();
    do_reset();
    n_vec++; if (sid_address !== 1'b0) begin n_err++; $display("FAIL pass_sid_c1: got %b want 0", sid_address); end
    repeat (2) tick();
    n_vec++; if (sid_address !== 1'b1) begin n_err++; $display("FAIL pass_sid_c3: got %b want 1", sid_address); end
    repeat (2) tick();
    n_vec++; if (check_done !== 1'b0) begin n_err++; $display("FAIL pass_done_c5: got %b want 0", check_done); end
    tick();
    n_vec++; if (check_done !== 1'b1) begin n_err++; $display("FAIL pass_done_c6: got %b want 1", check_done); end
    n_vec++; if ({id_ok, ts_ok, check_fail} !== 3'b110) begin n_err++; $display("FAIL pass_status: got %b want 110", {id_ok, ts_ok, check_fail}); end
    n_vec++; if (retry_cnt !== 3'd0) begin n_err++; $display("FAIL pass_retry: got %0d want 0", retry_cnt); end
    n_vec++; if (host_waitrequest !== 1'b0) begin n_err++; $display("FAIL pass_waitreq: got %b want 0", host_waitrequest); end
  endtask

  task automatic test_host_read();
    int w, l, n;
    logic [31:0] d;
    do_read(1'b0, w, l, d, n);
    n_vec++; if (w !== 0) begin n_err++; $display("FAIL hr_stall: got %0d want 0", w); end
    n_vec++; if (l !== 3) begin n_err++; $display("FAIL hr_latency: got %0d want 3", l); end
    n_vec++; if (d !== ID_GOOD) begin n_err++; $display("FAIL hr_data: got %h want %h", d, ID_GOOD); end
    n_vec++; if (n !== 1) begin n_err++; $display("FAIL hr_strobes: got %0d want 1", n); end
  endtask

  task automatic test_back_to_back();
    host_read = 1'b1;
    host_address = 1'b0;
    tick();
    host_read = 1'b0;
    n_vec++; if (host_waitrequest !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", host_waitrequest); end
    repeat (2) tick();
    n_vec++; if ({host_readdatavalid, host_readdata} !== {1'b1, ID_GOOD}) begin n_err++; $display("FAIL b2b_first: got %b/%h want 1/%h", host_readdatavalid, host_readdata, ID_GOOD); end
    n_vec++; if (host_waitrequest !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b want 0", host_waitrequest); end
    host_read = 1'b1;
    host_address = 1'b1;
    tick();
    host_read = 1'b0;
    n_vec++; if ({host_readdatavalid, sid_address} !== 2'b01) begin n_err++; $display("FAIL b2b_second_issue: got %b want 01", {host_readdatavalid, sid_address}); end
    repeat (2) tick();
    n_vec++; if ({host_readdatavalid, host_readdata} !== {1'b1, TS_GOOD}) begin n_err++; $display("FAIL b2b_second: got %b/%h want 1/%h", host_readdatavalid, host_readdata, TS_GOOD); end
    tick();
  endtask

  task automatic test_contention();
    int w, l, n;
    logic [31:0] d;
    host_read = 1'b1;
    host_address = 1'b1;
    do_reset();
    do_read(1'b1, w, l, d, n);
    n_vec++; if (w !== 5) begin n_err++; $display("FAIL cont_stall: got %0d want 5", w); end
    n_vec++; if (l !== 3) begin n_err++; $display("FAIL cont_latency: got %0d want 3", l); end
    n_vec++; if (d !== TS_GOOD) begin n_err++; $display("FAIL cont_data: got %h want %h", d, TS_GOOD); end
    n_vec++; if (n !== 1) begin n_err++; $display("FAIL cont_strobes: got %0d want 1", n); end
  endtask

  task automatic test_mid_read_reset();
    int n = 0;
    host_read = 1'b1;
    host_address = 1'b0;
    tick();
    host_read = 1'b0;
    reset = 1'b1;
    tick();
    n_vec++; if ({host_waitrequest, host_readdatavalid, check_done, retry_cnt} !== 6'b100000) begin n_err++; $display("FAIL mrr_outputs: got %b want 100000", {host_waitrequest, host_readdatavalid, check_done, retry_cnt}); end
    n_vec++; if ({host_readdata, sid_address, id_ok, ts_ok, check_fail} !== 36'h0) begin n_err++; $display("FAIL mrr_data: got %h want 0", {host_readdata, sid_address, id_ok, ts_ok, check_fail}); end
    reset = 1'b0;
    repeat (5) begin
      tick();
      if (host_readdatavalid) n++;
    end
    n_vec++; if (n !== 0) begin n_err++; $display("FAIL mrr_strobes: got %0d want 0", n); end
    n_vec++; if ({check_done, id_ok, ts_ok} !== 3'b111) begin n_err++; $display("FAIL mrr_recheck: got %b want 111", {check_done, id_ok, ts_ok}); end
  endtask

  task automatic test_transient();
    slave_id = ID_BAD;
    do_reset();
    repeat (2) tick();
    slave_id = ID_GOOD;
    repeat (3) tick();
    n_vec++; if ({check_done, id_ok, retry_cnt} !== 5'b00001) begin n_err++; $display("FAIL tr_first_pass: got %b want 00001", {check_done, id_ok, retry_cnt}); end
    repeat (4) tick();
    n_vec++; if (check_done !== 1'b0) begin n_err++; $display("FAIL tr_done_c10: got %b want 0", check_done); end
    tick();
    n_vec++; if ({check_done, id_ok, ts_ok, check_fail} !== 4'b1110) begin n_err++; $display("FAIL tr_status: got %b want 1110", {check_done, id_ok, ts_ok, check_fail}); end
    n_vec++; if (retry_cnt !== 3'd1) begin n_err++; $display("FAIL tr_retry: got %0d want 1", retry_cnt); end
  endtask

  task automatic test_persistent();
    int w, l, n;
    logic [31:0] d;
    slave_ts = TS_BAD;
    do_reset();
    repeat (19) tick();
    n_vec++; if (check_done !== 1'b0) begin n_err++; $display("FAIL pf_done_c20: got %b want 0", check_done); end
    tick();
    n_vec++; if ({check_done, id_ok, ts_ok, check_fail} !== 4'b1101) begin n_err++; $display("FAIL pf_status: got %b want 1101", {check_done, id_ok, ts_ok, check_fail}); end
    n_vec++; if (retry_cnt !== 3'd3) begin n_err++; $display("FAIL pf_retry: got %0d want 3", retry_cnt); end
    do_read(1'b1, w, l, d, n);
    n_vec++; if ({w, l, n} !== {32'd0, 32'd3, 32'd1}) begin n_err++; $display("FAIL pf_read_timing: got %0d/%0d/%0d want 0/3/1", w, l, n); end
    n_vec++; if (d !== TS_BAD) begin n_err++; $display("FAIL pf_read_data: got %h want %h", d, TS_BAD); end
    n_vec++; if (check_fail !== 1'b1) begin n_err++; $display("FAIL pf_sticky: got %b want 1", check_fail); end
    slave_ts = TS_GOOD;
  endtask

`ifdef SYSID_PERIODIC_CHECK_EN
  task automatic test_periodic();
    do_reset();
    repeat (5) tick();
    slave_id = ID_BAD;
    repeat (15) tick();
    n_vec++; if ({check_done, host_waitrequest} !== 2'b10) begin n_err++; $display("FAIL per_c21: got %b want 10", {check_done, host_waitrequest}); end
    tick();
    n_vec++; if ({check_done, host_waitrequest, retry_cnt} !== 5'b01000) begin n_err++; $display("FAIL per_restart: got %b want 01000", {check_done, host_waitrequest, retry_cnt}); end
    repeat (20) tick();
    n_vec++; if ({check_done, check_fail, id_ok, retry_cnt} !== 6'b110011) begin n_err++; $display("FAIL per_fail: got %b want 110011", {check_done, check_fail, id_ok, retry_cnt}); end
    repeat (15) tick();
    host_read = 1'b1;
    host_address = 1'b0;
    tick();
    host_read = 1'b0;
    n_vec++; if ({host_waitrequest, check_done} !== 2'b11) begin n_err++; $display("FAIL per_host_first: got %b want 11", {host_waitrequest, check_done}); end
    repeat (2) tick();
    n_vec++; if ({host_readdatavalid, host_readdata} !== {1'b1, ID_BAD}) begin n_err++; $display("FAIL per_host_data: got %b/%h want 1/%h", host_readdatavalid, host_readdata, ID_BAD); end
    n_vec++; if ({check_done, check_fail, host_waitrequest} !== 3'b011) begin n_err++; $display("FAIL per_recheck_after_rd: got %b want 011", {check_done, check_fail, host_waitrequest}); end
    slave_id = ID_GOOD;
  endtask
`else
  task automatic test_single_check();
    do_reset();
    repeat (45) tick();
    n_vec++; if ({check_done, host_waitrequest, retry_cnt} !== 5'b10000) begin n_err++; $display("FAIL single_terminal: got %b want 10000", {check_done, host_waitrequest, retry_cnt}); end
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_host_read();
    test_back_to_back();
    test_contention();
    test_mid_read_reset();
    test_transient();
    test_persistent();
`ifdef SYSID_PERIODIC_CHECK_EN
    test_periodic();
`else
    test_single_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
